fp_align: RTL and testbench
===========================

// Module: fp_align
// PURPOSE
//  - Pre-add operand alignment: orders two FP operands by magnitude, right-shifts the smaller mantissa by the exponent difference.
//  - Outputs both mantissas in the (2*M+3)-bit extended format consumed by the adder and then fp_normalize.
//  - Two-stage pipeline with valid/ready handshake. Sits in the CUDA-core FPU add path between operand unpack and the mantissa adder.
// PARAMETERS
//  M  23  stored mantissa width (hidden bit excluded; inputs carry M+1 bits)
//  E  8   exponent width (ports carry E+1 bits, same as fp_normalize)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  a_m        in   M+1      operand A mantissa, hidden bit at [M]
//  a_e        in   E+1      operand A biased exponent
//  b_m        in   M+1      operand B mantissa, hidden bit at [M]
//  b_e        in   E+1      operand B biased exponent
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block accepts beat when in_valid&&in_ready
//  big_m      out  2*M+3    larger operand: {1'b0, m, (M+1)'b0}
//  small_m    out  2*M+3    smaller operand, extended then shifted right by d
//  out_e      out  E+1      exponent of larger operand
//  swap       out  1        1 = B was larger (big=B, small=A)
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts when out_valid&&out_ready
// BEHAVIOUR
//  - Reset (rst=1 at edge): s1_valid=0, s2_valid=0. out_valid=0. big_m/small_m/out_e/swap=0. in_ready=0 while rst high.
//  - Stage 1 (compare): swap = (b_e>a_e) || (b_e==a_e && b_m>a_m). Equal operands give swap=0.
//  - Stage 1 registers big/small mantissas and exponents, plus d = e_big - e_small (unsigned, E+1 bits, never negative).
//  - Stage 2 (shift): small_m = {1'b0, m_small, (M+1)'b0} >> min(d, 2*M+3); big_m = {1'b0, m_big, (M+1)'b0}. Result registered to outputs.
//  - Shift saturation: d >= 2*M+3 gives small_m = 0, apart from the sticky bit below.
//  - Guard field: the low M+1 zero bits mean no mantissa bit is lost for d <= M+1.
//  - Latency: exactly 2 cycles from accepted input to out_valid when unstalled. Throughput 1 beat/cycle.
//  - Handshake:
//    - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv && !rst.
//    - Outputs hold stable while out_valid && !out_ready.
//    - in_ready drops combinationally from out_ready when both stages are full. No skid buffer.
//  - Stage 1 and stage 2 may advance in the same cycle: a full pipeline streams with out_ready=1.
//  - Bubbles: a stage with no valid beat loads its valid=0 and keeps stale data. Data regs need no reset except the outputs.
//  - in_valid without in_ready: beat not taken; source must hold it. Block never drops or duplicates beats.
//  - Zero/denormal inputs (hidden bit 0) are aligned identically; no special-case handling (NaN/Inf handled upstream).
//  - rst mid-operation: both stages flushed next edge, in-flight beats discarded, out_valid=0 the cycle after.
// CONFIGURATION
//  - FP_ALIGN_STICKY_EN defined:
//    - small_m[0] = small_m_shifted[0] | OR(all bits shifted out past bit 0), including the fully-saturated case.
//  - FP_ALIGN_STICKY_EN undefined:
//    - Shifted-out bits are discarded; small_m is the plain truncated shift. Saves the OR-reduce tree.
// TESTING (M=23, E=8)
//  1. a_e=130,b_e=127,a_m=24'h800000,b_m=24'hC00000,out_ready=1
//     -> 2 cycles later: swap=0, out_e=130, big_m=49'h800000000000, small_m=49'h180000000000
//  2. a_e=a_b, a_m=24'h900000<b_m=24'hA00000, exps 127
//     -> swap=1, out_e=127, big_m=49'hA00000000000, small_m=49'h900000000000
//  3. a_e=200,b_e=100,b_m=24'h800001
//     -> small_m=49'h1 with FP_ALIGN_STICKY_EN, 49'h0 without; big_m from a_m
//  4. stream 8 beats back-to-back, out_ready=0 cycles 3-5
//     -> in_ready=0 once both stages full; all 8 outputs appear in order, none lost/duplicated, outputs stable while stalled
//  5. rst=1 for 1 cycle with 2 beats in flight
//     -> out_valid=0 next cycle; in_ready=0 during rst, 1 after; first post-reset beat out after 2 cycles
//  6. d=24 (a_e=151,b_e=127), b_m=24'hFFFFFF
//     -> small_m=49'h000000FFFFFF; sticky bit not set in either config

Source files
------------

// File: rtl/fp_align.sv
// Pre-add operand alignment: orders two FP operands by magnitude and right-shifts the smaller
// mantissa by the exponent difference. Optional sticky OR of shifted-out bits: FP_ALIGN_STICKY_EN.
module fp_align #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M:0]       a_m,
    input  logic [E:0]       a_e,
    input  logic [M:0]       b_m,
    input  logic [E:0]       b_e,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*M+2:0]   big_m,
    output logic [2*M+2:0]   small_m,
    output logic [E:0]       out_e,
    output logic             swap,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int W = 2*M+3;
    localparam int G = M+1;

    function automatic logic [W-1:0] extend(input logic [M:0] m);
        return {1'b0, m, {G{1'b0}}};
    endfunction

`ifdef FP_ALIGN_STICKY_EN
    // OR of every bit position below the shift amount, i.e. the bits a right shift by d discards.
    function automatic logic lost_or(input logic [W-1:0] v, input logic [E:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(d)) begin
                acc = acc | v[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction
`endif

    logic           swap_s;
    logic [M:0]     big_m_s;
    logic [M:0]     small_m_s;
    logic [E:0]     big_e_s;
    logic [E:0]     diff_s;

    logic           s1_valid_r;
    logic [M:0]     s1_big_m_r;
    logic [M:0]     s1_small_m_r;
    logic [E:0]     s1_e_r;
    logic [E:0]     s1_d_r;
    logic           s1_swap_r;

    logic           s1_adv_s;
    logic           s2_adv_s;
    logic [W-1:0]   small_ext_s;
    logic [W-1:0]   shifted_s;
    logic [W-1:0]   small_fin_s;

    assign s2_adv_s = !out_valid || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s && !rst;

    // Stage-1 magnitude compare and operand ordering; ties keep A as the larger operand.
    always_comb begin
        swap_s = (b_e > a_e) || ((b_e == a_e) && (b_m > a_m));
        if (swap_s) begin
            big_m_s   = b_m;
            small_m_s = a_m;
            big_e_s   = b_e;
            diff_s    = b_e - a_e;
        end else begin
            big_m_s   = a_m;
            small_m_s = b_m;
            big_e_s   = a_e;
            diff_s    = a_e - b_e;
        end
    end

    // Stage-1 pipeline register; data is only captured with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_big_m_r   <= big_m_s;
                s1_small_m_r <= small_m_s;
                s1_e_r       <= big_e_s;
                s1_d_r       <= diff_s;
                s1_swap_r    <= swap_s;
            end
        end
    end

    // Stage-2 alignment shift, saturating to zero once d covers the whole extended field.
    always_comb begin
        small_ext_s = extend(s1_small_m_r);
        if (s1_d_r >= (E+1)'(W)) begin
            shifted_s = {W{1'b0}};
        end else begin
            shifted_s = small_ext_s >> s1_d_r;
        end
        small_fin_s = shifted_s;
`ifdef FP_ALIGN_STICKY_EN
        small_fin_s[0] = shifted_s[0] | lost_or(small_ext_s, s1_d_r);
`endif
    end

    // Stage-2 output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            big_m     <= {W{1'b0}};
            small_m   <= {W{1'b0}};
            out_e     <= {(E+1){1'b0}};
            swap      <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                big_m   <= extend(s1_big_m_r);
                small_m <= small_fin_s;
                out_e   <= s1_e_r;
                swap    <= s1_swap_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_align.sv
// Directed self-checking bench for fp_align (M=23, E=8); expectations follow FP_ALIGN_STICKY_EN.
module tb_fp_align;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   a_m, b_m;
    logic [8:0]    a_e, b_e;
    logic          in_valid, in_ready;
    logic [48:0]   big_m, small_m;
    logic [8:0]    out_e;
    logic          swap, out_valid, out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    fp_align #(.M(23), .E(8)) dut (
        .clk(clk), .rst(rst),
        .a_m(a_m), .a_e(a_e), .b_m(b_m), .b_e(b_e),
        .in_valid(in_valid), .in_ready(in_ready),
        .big_m(big_m), .small_m(small_m), .out_e(out_e), .swap(swap),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [23:0] am, input logic [8:0] ae,
                         input logic [23:0] bm, input logic [8:0] be);
        a_m = am; a_e = ae; b_m = bm; b_e = be;
    endtask

    // One isolated beat: out_valid must be low after one edge and high after two.
    task automatic run_vec(input string tag,
                           input logic [23:0] am, input logic [8:0] ae,
                           input logic [23:0] bm, input logic [8:0] be,
                           input logic e_swap, input logic [8:0] e_e,
                           input logic [48:0] e_big, input logic [48:0] e_small);
        drive(am, ae, bm, be);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_swap"}, swap, e_swap);
        check({tag, "_e"}, out_e, e_e);
        check({tag, "_big"}, big_m, e_big);
        check({tag, "_small"}, small_m, e_small);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic         sticky;
        int           in_idx, out_idx;
        logic         stall_prev, h_valid, h_swap;
        logic [48:0]  h_big, h_small, exp_small_base;
        logic [8:0]   h_e;

`ifdef FP_ALIGN_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(24'h0, 9'd0, 24'h0, 9'd0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_big", big_m, 49'h0);
        check("rst_small", small_m, 49'h0);
        check("rst_e", out_e, 9'd0);
        check("rst_swap", swap, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        run_vec("t1", 24'h800000, 9'd130, 24'hC00000, 9'd127,
                1'b0, 9'd130, 49'h800000000000, 49'h180000000000);
        run_vec("t2", 24'h900000, 9'd127, 24'hA00000, 9'd127,
                1'b1, 9'd127, 49'hA00000000000, 49'h900000000000);
        run_vec("t3", 24'h800000, 9'd200, 24'h800001, 9'd100,
                1'b0, 9'd200, 49'h800000000000, {48'h0, sticky});
        run_vec("t6", 24'h800000, 9'd151, 24'hFFFFFF, 9'd127,
                1'b0, 9'd151, 49'h800000000000, 49'h000000FFFFFF);
        run_vec("d47", 24'h800000, 9'd174, 24'h800000, 9'd127,
                1'b0, 9'd174, 49'h800000000000, 49'h1);
        run_vec("d49", 24'h800000, 9'd176, 24'h800000, 9'd127,
                1'b0, 9'd176, 49'h800000000000, {48'h0, sticky});
        run_vec("eq", 24'h123456, 9'd90, 24'h123456, 9'd90,
                1'b0, 9'd90, 49'h123456000000, 49'h123456000000);

        // Eight-beat stream with the consumer stalled for cycles 3-5.
        in_idx = 0; out_idx = 0; stall_prev = 1'b0;
        h_valid = 1'b0; h_swap = 1'b0; h_big = '0; h_small = '0; h_e = '0;
        exp_small_base = 49'h180000000000;
        for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (in_idx < 8);
            drive(24'h800000 + 24'(in_idx), 9'd130 + 9'(in_idx), 24'hC00000, 9'd127);
            #2;
            if (cyc == 3) check("stream_in_ready_stall", in_ready, 1'b0);
            if (stall_prev) begin
                check("stall_valid", out_valid, h_valid);
                check("stall_big", big_m, h_big);
                check("stall_small", small_m, h_small);
                check("stall_e", out_e, h_e);
                check("stall_swap", swap, h_swap);
            end
            if (out_valid && out_ready) begin
                check("stream_e", out_e, 9'd130 + 9'(out_idx));
                check("stream_big", big_m, {1'b0, 24'h800000 + 24'(out_idx), 24'h0});
                check("stream_small", small_m, exp_small_base >> out_idx);
                check("stream_swap", swap, 1'b0);
                out_idx++;
            end
            stall_prev = out_valid && !out_ready;
            h_valid = out_valid; h_big = big_m; h_small = small_m; h_e = out_e; h_swap = swap;
            if (in_valid && in_ready) in_idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_in_count", in_idx, 8);
        check("stream_out_count", out_idx, 8);
        tick();
        tick();

        // Reset with two beats in flight, then one fresh beat.
        drive(24'h800000, 9'd130, 24'hC00000, 9'd127);
        in_valid = 1'b1;
        tick();
        drive(24'h900000, 9'd127, 24'hA00000, 9'd127);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", in_ready, 1'b1);
        drive(24'h800000, 9'd151, 24'hFFFFFF, 9'd127);
        tick();
        in_valid = 1'b0;
        check("after_rst_lat1", out_valid, 1'b0);
        tick();
        check("after_rst_valid", out_valid, 1'b1);
        check("after_rst_e", out_e, 9'd151);
        check("after_rst_small", small_m, 49'h000000FFFFFF);
        tick();
        check("after_rst_drain", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
